// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the processor data-memory port. Holds DEPTH
// 32-bit words, posts every write through a one-entry buffer that commits
// on the following edge, and answers reads combinationally with forwarding
// from that buffer. A hardware clear walks the whole array after reset
// before any access is accepted. Saturating read/write counters are exposed.
//
// Optional feature: define DMEM_PARITY_CHECK_EN to store an even-parity bit
// per word and add the parity_inject input and parity_err output.
//
// state    | meaning
// ST_INIT  | clearing mem[ptr] each cycle; strobes ignored, output forced to 0
// ST_READY | accepting reads/writes until the next rst
module data_mem_responder #(
    parameter int DEPTH = 128,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     CEN,
    input  logic                     WEN,
    input  logic                     OEN,
    input  logic [$clog2(DEPTH)-1:0] A,
    input  logic [31:0]              Data2Mem,
    output logic [31:0]              ReadDataMem,
    output logic                     init_done,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count
`ifdef DMEM_PARITY_CHECK_EN
    ,
    input  logic                     parity_inject,
    output logic                     parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] ptr;
    logic [31:0]   mem [DEPTH];

    logic          pending_valid;
    logic [AW-1:0] pending_addr;
    logic [31:0]   pending_data;

    logic is_ready;
    logic acc;
    logic wr_acc;
    logic rd_acc;
    logic rd_out;
    logic fwd;

    // Access decode. A combined WEN=0/OEN=0 strobe is a write for counting and
    // posting, but still drives the pre-write value onto ReadDataMem.
    assign is_ready = (state == ST_READY);
    assign acc      = is_ready && !CEN;
    assign wr_acc   = acc && !WEN;
    assign rd_acc   = acc && WEN && !OEN;
    assign rd_out   = acc && !OEN;
    assign fwd      = pending_valid && (pending_addr == A);

    // Clear sequencer: walk ptr over every word once, then stay READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + 1'b1;
            if (ptr == AW'(DEPTH - 1)) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end
    end

    // Posted-write buffer: a new write replaces the entry being committed
    // this same edge, so back-to-back writes keep the later value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid <= 1'b0;
        end else if (wr_acc) begin
            pending_valid <= 1'b1;
            pending_addr  <= A;
            pending_data  <= Data2Mem;
        end else if (is_ready) begin
            pending_valid <= 1'b0;
        end
    end

    // Single array write port: clear during INIT, pending commit when READY.
    // A reset edge writes nothing, so a posted write is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[ptr] <= '0;
            end else if (pending_valid) begin
                mem[pending_addr] <= pending_data;
            end
        end
    end

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && (rd_count != '1)) rd_count <= rd_count + 1'b1;
            if (wr_acc && (wr_count != '1)) wr_count <= wr_count + 1'b1;
        end
    end

    // Zero-latency read path with forwarding from the posted entry.
    always_comb begin
        ReadDataMem = '0;
        if (rd_out) begin
            ReadDataMem = fwd ? pending_data : mem[A];
        end
    end

`ifdef DMEM_PARITY_CHECK_EN
    logic mem_par [DEPTH];
    logic pending_par;

    // Parity for the posted entry; inversion on inject lets the bench force an error.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            pending_par <= (^Data2Mem) ^ parity_inject;
        end
    end

    // Parity array follows the data array's write port exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_par[ptr] <= 1'b0;
            end else if (pending_valid) begin
                mem_par[pending_addr] <= pending_par;
            end
        end
    end

    // Flag a mismatch between the stored bit and the data actually returned.
    always_comb begin
        parity_err = 1'b0;
        if (rd_out) begin
            parity_err = (fwd ? pending_par : mem_par[A]) != (^ReadDataMem);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes the expected read
// result for every read strobe; a negedge monitor pops and compares.
module tb_data_mem_responder;

    localparam int TB_CNT_W = 4;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                CEN = 1'b1;
    logic                WEN = 1'b1;
    logic                OEN = 1'b1;
    logic [6:0]          A = '0;
    logic [31:0]         Data2Mem = '0;
    logic [31:0]         ReadDataMem;
    logic                init_done;
    logic [TB_CNT_W-1:0] rd_count;
    logic [TB_CNT_W-1:0] wr_count;
    logic                obs_p;

`ifdef DMEM_PARITY_CHECK_EN
    logic parity_inject = 1'b0;
    logic parity_err;
    assign obs_p = parity_err;
`else
    assign obs_p = 1'b0;
`endif

    data_mem_responder #(.DEPTH(128), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .init_done   (init_done),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`ifdef DMEM_PARITY_CHECK_EN
        ,
        .parity_inject (parity_inject),
        .parity_err    (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic mon_en = 1'b0;
    logic tb_ready = 1'b0;
    logic [TB_CNT_W-1:0] exp_rd = '0;
    logic [TB_CNT_W-1:0] exp_wr = '0;

    function automatic void chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    // Monitor: every read strobe consumes one expectation; otherwise the output must be 0.
    always @(negedge clk) begin
        logic [32:0] e;
        if (mon_en) begin
            if (!CEN && !OEN) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL read_unexpected got=%h exp=none", ReadDataMem);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", {obs_p, ReadDataMem}, e);
                end
            end else begin
                chk("idle_out", {obs_p, ReadDataMem}, 33'h0);
            end
        end
    end

    task automatic op(input logic cen, input logic wen, input logic oen,
                      input logic [6:0] a, input logic [31:0] d, input logic [32:0] e);
        CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
        if (!cen && !oen) exp_q.push_back(e);
        if (tb_ready && !cen) begin
            if (!wen) begin
                if (exp_wr != CNT_MAX) exp_wr = exp_wr + 1'b1;
            end else if (!oen) begin
                if (exp_rd != CNT_MAX) exp_rd = exp_rd + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 33'h0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        op(1'b0, 1'b0, 1'b1, a, d, 33'h0);
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] e);
        op(1'b0, 1'b1, 1'b0, a, 32'h0, {1'b0, e});
    endtask

    task automatic check_counts(input string name);
        chk({name, "_rd"}, {29'h0, rd_count}, {29'h0, exp_rd});
        chk({name, "_wr"}, {29'h0, wr_count}, {29'h0, exp_wr});
    endtask

    initial begin
        logic init_low_ok;
        int n;

        // Reset and clear sequence with strobe activity that must be ignored.
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tb_ready = 1'b0;
        init_low_ok = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (init_done !== 1'b0) init_low_ok = 1'b0;
            if (i == 10) rd(7'd5, 32'h0);
            else if (i == 20) wr(7'd6, 32'h55);
            else idle();
        end
        chk("init_low_128", {32'h0, init_low_ok}, 33'h1);
        chk("init_done_high", {32'h0, init_done}, 33'h1);
        tb_ready = 1'b1;
        check_counts("cnt_after_init");
        rd(7'd0, 32'h0);
        rd(7'd127, 32'h0);
        rd(7'd6, 32'h0);

        // Disabled strobes: CEN high with WEN low, and CEN low with nothing enabled.
        op(1'b1, 1'b0, 1'b0, 7'd10, 32'hFFFF, 33'h0);
        op(1'b0, 1'b1, 1'b1, 7'd10, 32'hFFFF, 33'h0);
        rd(7'd10, 32'h0);

        // Forwarding then array read.
        wr(7'd5, 32'hDEADBEEF);
        rd(7'd5, 32'hDEADBEEF);
        idle();
        rd(7'd5, 32'hDEADBEEF);
        check_counts("cnt_deadbeef");

        // Back-to-back writes to one address keep the later value.
        wr(7'd9, 32'h1);
        wr(7'd9, 32'h2);
        rd(7'd9, 32'h2);
        idle();
        rd(7'd9, 32'h2);

        // Combined write+read returns the pre-write value.
        wr(7'd3, 32'h77);
        idle();
        op(1'b0, 1'b0, 1'b0, 7'd3, 32'hAAAA5555, {1'b0, 32'h77});
        rd(7'd3, 32'hAAAA5555);
        check_counts("cnt_combined");

`ifdef DMEM_PARITY_CHECK_EN
        parity_inject = 1'b1;
        wr(7'd7, 32'h3);
        parity_inject = 1'b0;
        op(1'b0, 1'b1, 1'b0, 7'd7, 32'h0, {1'b1, 32'h3});
        idle();
        op(1'b0, 1'b1, 1'b0, 7'd7, 32'h0, {1'b1, 32'h3});
        wr(7'd8, 32'h5);
        op(1'b0, 1'b1, 1'b0, 7'd8, 32'h0, {1'b0, 32'h5});
        idle();
        op(1'b0, 1'b1, 1'b0, 7'd8, 32'h0, {1'b0, 32'h5});
`endif

        // Reset right after a posted write: write is lost, clear reruns.
        wr(7'd4, 32'h12);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        tb_ready = 1'b0;
        exp_rd = '0;
        exp_wr = '0;
        n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            idle();
            n++;
        end
        chk("reinit_cycles", {1'b0, 32'(n)}, {1'b0, 32'd128});
        tb_ready = 1'b1;
        check_counts("cnt_after_reset");
        rd(7'd4, 32'h0);
        rd(7'd9, 32'h0);

        // Counter saturation.
        for (int i = 0; i < 20; i++) rd(7'd0, 32'h0);
        for (int i = 0; i < 20; i++) wr(7'd1, 32'(i));
        chk("rd_sat", {29'h0, rd_count}, {29'h0, CNT_MAX});
        chk("wr_sat", {29'h0, wr_count}, {29'h0, CNT_MAX});
        rd(7'd1, 32'd19);
        check_counts("cnt_final");
        idle();

        chk("queue_drained", {1'b0, 32'(exp_q.size())}, 33'h0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor data-memory port: decodes the CEN/WEN/OEN/A/Data2Mem strobes and returns ReadDataMem.
- Holds 128 x 32-bit words and posts each write through a one-entry buffer, which commits on the following cycle.
- Reads are combinational, so the single-cycle core sees data in the same cycle, with forwarding from the posted buffer.
- After reset, a hardware clear sequence zeroes the array before accesses are accepted; saturating access counters are provided for the bench.

Parameters:
- DEPTH, 128, number of 32-bit words; address width is log2(DEPTH) = 7.
- CNT_W, 16, width of each access counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- CEN  input  1  chip enable, active-low.
- WEN  input  1  write enable, active-low; meaningful only when CEN=0.
- OEN  input  1  output enable (read), active-low; meaningful only when CEN=0.
- A  input  7  word address.
- Data2Mem  input  32  write data.
- ReadDataMem  output  32  read data.
- init_done  output  1  high once the clear sequence has finished.
- rd_count  output  CNT_W  accepted reads, saturating.
- wr_count  output  CNT_W  accepted writes, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=INIT, clear pointer<=0, pending_valid<=0 (any posted write is discarded), rd_count<=0, wr_count<=0, init_done<=0.
  - rst dominates every other input, including in the middle of INIT or a write.
- State machine:
  - INIT: each cycle, mem[ptr]<=0 and ptr<=ptr+1. When ptr==DEPTH-1, the next state is READY and init_done<=1 (clear takes exactly 128 cycles after reset deasserts).
  - READY: the terminal state until the next rst.
- During INIT:
  - Strobes are ignored; ReadDataMem=0.
  - Counters hold and nothing is posted.
- READY, write (CEN=0, WEN=0):
  - At the edge, pending_addr<=A, pending_data<=Data2Mem, pending_valid<=1.
  - The previous pending entry, if valid, commits to mem in the same edge. Commit-then-post order is required, so back-to-back writes to the same address end with the later value.
- READY, no write:
  - If pending_valid, mem[pending_addr]<=pending_data and pending_valid<=0.
- READY, read (CEN=0, OEN=0, WEN=1):
  - If pending_valid and pending_addr==A, ReadDataMem=pending_data (forwarding); otherwise ReadDataMem=mem[A].
  - Combinational, zero-cycle latency.
- WEN=0 and OEN=0 in the same cycle:
  - Treated as a write.
  - ReadDataMem returns the pre-write value: forwarded pending data or array content, excluding the current Data2Mem.
  - Counts as a write only.
- Idle or disabled (CEN=1, or CEN=0 with WEN=1 and OEN=1):
  - ReadDataMem=0.
  - No count, and no state change other than the pending commit.
- Counters:
  - rd_count increments on each READY-state read edge; wr_count increments on each READY-state write edge.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Address: the full 7-bit range is valid, so there are no out-of-range cases. Arithmetic on ptr is modulo DEPTH, but the clear stops at DEPTH-1.

Optional Feature:
- Macro: DMEM_PARITY_CHECK_EN.
- Enabled:
  - Each stored word carries an even-parity bit computed on write; INIT clears it to 0.
  - The forwarded pending entry carries its own parity bit.
  - Extra output parity_err (1 bit), combinational: asserts during a READY-state read when the stored bit differs from the XOR of the returned 32-bit data; otherwise 0.
  - Extra input parity_inject (1 bit): when high during a write, the stored parity bit is inverted, for test.
- Disabled:
  - Neither port exists; no parity storage.

Test Plan:
- Reset, then hold strobes idle: init_done=0 for 128 cycles after rst falls and 1 thereafter; every address reads 32'h0; counters are 0.
- Write A=5 with 32'hDEADBEEF, then read A=5 on the next cycle: ReadDataMem=32'hDEADBEEF via forwarding. After one idle cycle, read A=5 again: still 32'hDEADBEEF, now from the array. wr_count=1, rd_count=2.
- Write A=9 with 32'h1, then A=9 with 32'h2 back-to-back, then read A=9: ReadDataMem=32'h2.
- CEN=0, WEN=0, OEN=0 at A=3 with Data2Mem=32'hAAAA5555, where mem[3]=32'h77: ReadDataMem=32'h77 that cycle and 32'hAAAA5555 on the next read. wr_count increments by 1, rd_count is unchanged.
- Write A=4 with 32'h12, assert rst on the next edge, then wait for init_done: reading A=4 returns 32'h0 and counters are 0.
- With DMEM_PARITY_CHECK_EN: write A=7 with parity_inject=1, then read A=7: parity_err=1. Write A=8 normally, then read A=8: parity_err=0.
